// File: rtl/nibble_serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_add_ctrl_pkg
// Description : Shared constants and FSM state encoding for the nibble-serial
//               adder sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_serial_add_ctrl_pkg;

    // Width of the single adder slice reused on every BUSY cycle
    localparam int NIBBLE_W = 4;

    // Sequencer states; the spare code falls back to idle
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_DONE    = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

endpackage : nibble_serial_add_ctrl_pkg
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl_nibble_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_adder
// Description : Purely combinational 4-bit ripple-carry slice built from a
//               chain of 1-bit full adders.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_adder
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    // Ripple carry chain: w_c[0] is the slice carry-in, w_c[NIBBLE_W] the carry-out
    logic [NIBBLE_W:0] w_c;

    assign w_c[0] = ci;

    generate
        for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
            assign s[i]     = x[i] ^ y[i] ^ w_c[i];
            assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
        end
    endgenerate

    assign co = w_c[NIBBLE_W];

endmodule : nibble_adder
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_add_ctrl
// Description : Sequencer that adds WIDTH-bit operands one nibble per cycle
//               through a single shared 4-bit adder slice, with valid/ready
//               handshakes on the operand and result sides.
//               Optional feature macro: SERIAL_ADD_OVF_EN (adds ovf output).
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(NIBBLES - 1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_a_sh;
    logic [WIDTH-1:0]     r_b_sh;
    logic [WIDTH-1:0]     r_sum_sh;
    logic                 r_carry;
    logic [CNT_W-1:0]     r_cnt;

    logic [NIBBLE_W-1:0]  w_s;
    logic                 w_co;
    logic [WIDTH-1:0]     w_sum_next;
    logic                 w_last;

    // Single shared slice: always works on the lowest nibble of the shifters
    nibble_adder u_slice (
        .x  (r_a_sh[NIBBLE_W-1:0]),
        .y  (r_b_sh[NIBBLE_W-1:0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // New slice result enters at the top; older nibbles move towards bit 0
    generate
        if (NIBBLES == 1) begin : g_single_nibble
            assign w_sum_next = w_s;
        end else begin : g_multi_nibble
            assign w_sum_next = {w_s, r_sum_sh[WIDTH-1:NIBBLE_W]};
        end
    endgenerate

    assign w_last = (r_cnt == C_CNT_LAST);

    // FSM, counter, shift registers and carry; async reset aborts any operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_a_sh   <= r_a_sh >> NIBBLE_W;
                    r_b_sh   <= r_b_sh >> NIBBLE_W;
                    r_sum_sh <= w_sum_next;
                    r_carry  <= w_co;
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign sum       = r_sum_sh;
    assign cout      = r_carry;

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB (rebuilt from the top operand bits
    // and the top sum bit, all visible on the final BUSY edge) XOR carry out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == ST_BUSY && w_last) begin
            r_ovf <= (r_a_sh[NIBBLE_W-1] ^ r_b_sh[NIBBLE_W-1] ^ w_s[NIBBLE_W-1]) ^ w_co;
        end else if (r_state != ST_DONE || out_ready) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule : nibble_serial_add_ctrl
`default_nettype wire
